snd_link: RTL and testbench

SND_LINK -- requirements
Module: snd_link

---
 rtl/snd_link.sv | 162 ++++++++++++++++
 tb/tb_snd_link.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snd_link.sv
// Serial word link: TX FIFO + 34-bit-time framer, and a mid-bit sampling
// receiver that hands words to the processor through a level interrupt.
module snd_link #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TX_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd,
    input  logic [31:0] interface_data,
    input  logic        int_ack,
    input  logic        err_clr,
    input  logic        rx_line,
    output logic        tx_line,
    output logic        interrupt_eth,
    output logic [31:0] interrupt_source_data,
    output logic        tx_full,
    output logic        tx_busy,
    output logic        overrun,
    output logic        frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(TX_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    // The IDLE detect cycle already consumed one cycle of the start bit.
    localparam logic [CW-1:0] START_MID = CW'(CLKS_PER_BIT / 2 - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- TX FIFO ----------------
    logic [31:0]   mem [TX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    state_t        tx_state, tx_nxt;

    assign tx_full = (count == (AW+1)'(TX_DEPTH));
    assign push    = snd && !tx_full;
    assign pop     = (tx_state == IDLE) && (count != '0);
    assign tx_busy = (count != '0) || (tx_state != IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= interface_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // ---------------- TX framer ----------------
    logic [CW-1:0] tx_cnt;
    logic [4:0]    tx_idx;
    logic [31:0]   tx_sh;
    logic          tx_bit_end;

    assign tx_bit_end = (tx_cnt == BIT_LAST);

    always_comb begin
        tx_nxt = tx_state;
        case (tx_state)
            IDLE:    if (count != '0) tx_nxt = START;
            START:   if (tx_bit_end) tx_nxt = DATA;
            DATA:    if (tx_bit_end && tx_idx == 5'd31) tx_nxt = STOP;
            STOP:    if (tx_bit_end) tx_nxt = IDLE;
            default: tx_nxt = IDLE;
        endcase
    end

    // tx_line is registered from the state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_nxt;
            tx_cnt   <= (tx_state == IDLE || tx_bit_end) ? '0 : tx_cnt + 1'b1;
            if (pop) begin
                tx_sh  <= mem[rd_ptr];
                tx_idx <= '0;
            end else if (tx_state == DATA && tx_bit_end) begin
                tx_sh  <= tx_sh >> 1;
                tx_idx <= tx_idx + 1'b1;
            end
            case (tx_state)
                START:   tx_line <= 1'b0;
                DATA:    tx_line <= tx_sh[0];
                default: tx_line <= 1'b1;
            endcase
        end
    end

    // ---------------- RX ----------------
    logic          rx_s1, rx_s2;
    state_t        rx_state, rx_nxt;
    logic [CW-1:0] rx_cnt;
    logic [4:0]    rx_idx;
    logic [31:0]   rx_sh;
    logic          sample, stop_ok, stop_bad, accept, drop;

    assign sample   = (rx_state == START && rx_cnt == START_MID) ||
                      ((rx_state == DATA || rx_state == STOP) && rx_cnt == BIT_LAST);
    assign stop_ok  = (rx_state == STOP) && sample && rx_s2;
    assign stop_bad = (rx_state == STOP) && sample && !rx_s2;
    assign accept   = stop_ok && (!interrupt_eth || int_ack);
    assign drop     = stop_ok && interrupt_eth && !int_ack;

    always_comb begin
        rx_nxt = rx_state;
        case (rx_state)
            IDLE:    if (!rx_s2) rx_nxt = START;
            START:   if (sample) rx_nxt = rx_s2 ? IDLE : DATA;
            DATA:    if (sample && rx_idx == 5'd31) rx_nxt = STOP;
            STOP:    if (sample) rx_nxt = IDLE;
            default: rx_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1                 <= 1'b1;
            rx_s2                 <= 1'b1;
            rx_state              <= IDLE;
            rx_cnt                <= '0;
            rx_idx                <= '0;
            rx_sh                 <= '0;
            interrupt_eth         <= 1'b0;
            interrupt_source_data <= '0;
            overrun               <= 1'b0;
            frame_err             <= 1'b0;
        end else begin
            rx_s1    <= rx_line;
            rx_s2    <= rx_s1;
            rx_state <= rx_nxt;
            rx_cnt   <= (rx_state == IDLE || sample) ? '0 : rx_cnt + 1'b1;
            if (rx_state == START) rx_idx <= '0;
            else if (rx_state == DATA && sample) begin
                rx_sh  <= {rx_s2, rx_sh[31:1]};
                rx_idx <= rx_idx + 1'b1;
            end
            if (accept) begin
                interrupt_source_data <= rx_sh;
                interrupt_eth         <= 1'b1;
            end else if (int_ack) begin
                interrupt_eth <= 1'b0;
            end
            // A same-cycle set beats the clear.
            overrun   <= drop     ? 1'b1 : (err_clr ? 1'b0 : overrun);
            frame_err <= stop_bad ? 1'b1 : (err_clr ? 1'b0 : frame_err);
        end
    end
endmodule

// File: tb/tb_snd_link.sv
// Bench for snd_link: line decoder for TX, frame driver plus flag model for RX.
module tb_snd_link;
    localparam int CPB = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, snd, int_ack, err_clr, rx_line;
    logic        tx_line, interrupt_eth, tx_full, tx_busy, overrun, frame_err;
    logic [31:0] interface_data, interrupt_source_data;
    logic        loop, rx_drv, mon_en;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] mon_q[$];
    int          mon_t[$];
    logic [31:0] exp_q[$];

    // behavioural RX model state
    logic        m_irq, m_ovr, m_fe;
    logic [31:0] m_data;

    assign rx_line = loop ? tx_line : rx_drv;

    snd_link #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .snd(snd), .interface_data(interface_data),
        .int_ack(int_ack), .err_clr(err_clr), .rx_line(rx_line), .tx_line(tx_line),
        .interrupt_eth(interrupt_eth), .interrupt_source_data(interrupt_source_data),
        .tx_full(tx_full), .tx_busy(tx_busy), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (tx_busy && n < 2000) begin tick(1); n++; end
        chk(tag, 32'(tx_busy), 32'd0);
    endtask

    task automatic wait_mon(input int k, input string tag);
        int n = 0;
        while (mon_q.size() < k && n < 3000) begin tick(1); n++; end
        chk(tag, 32'(mon_q.size()), 32'(k));
    endtask

    task automatic send_frame(input logic [31:0] w, input bit good_stop);
        rx_drv = 1'b0; tick(CPB);
        for (int i = 0; i < 32; i++) begin rx_drv = w[i]; tick(CPB); end
        if (good_stop) begin
            rx_drv = 1'b1; tick(CPB);
        end else begin
            rx_drv = 1'b0; tick(CPB / 2);
            rx_drv = 1'b1; tick(CPB / 2);
        end
        tick(4);
    endtask

    task automatic model_frame(input logic [31:0] w, input bit good_stop);
        if (!good_stop) m_fe = 1'b1;
        else if (!m_irq) begin m_irq = 1'b1; m_data = w; end
        else m_ovr = 1'b1;
    endtask

    // Line decoder: samples tx_line at bit mid-points on the falling clock edge.
    initial begin
        logic [31:0] w;
        bit          ok;
        int          t0;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && tx_line === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(negedge clk);
                ok = (tx_line === 1'b0);
                for (int i = 0; i < 32; i++) begin
                    repeat (CPB) @(negedge clk);
                    w[i] = tx_line;
                end
                repeat (CPB) @(negedge clk);
                ok = ok && (tx_line === 1'b1);
                mon_q.push_back(ok ? w : 32'hDEAD_DEAD);
                mon_t.push_back(t0);
            end
        end
    end

    initial begin
        logic [31:0] w, wv[6];
        int k;
        bit good;
        rst_n = 1'b0; snd = 1'b0; interface_data = '0; int_ack = 1'b0; err_clr = 1'b0;
        rx_drv = 1'b1; loop = 1'b0; mon_en = 1'b1;
        tick(3);
        chk("rst_tx_line", 32'(tx_line), 32'd1);
        chk("rst_irq", 32'(interrupt_eth), 32'd0);
        chk("rst_data", interrupt_source_data, 32'd0);
        chk("rst_full", 32'(tx_full), 32'd0);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // loopback single word: exact latency of line and interrupt
        loop = 1'b1;
        snd = 1'b1; interface_data = 32'hA5A5_0F0F;
        tick(1); snd = 1'b0;
        tick(1); chk("lb_line_n1", 32'(tx_line), 32'd1);
        tick(1); chk("lb_line_n2", 32'(tx_line), 32'd0);
        tick(135); chk("lb_irq_early", 32'(interrupt_eth), 32'd0);
        tick(1); chk("lb_irq", 32'(interrupt_eth), 32'd1);
        chk("lb_data", interrupt_source_data, 32'hA5A5_0F0F);
        wait_mon(1, "lb_mon_cnt");
        if (mon_q.size() > 0) chk("lb_mon_word", mon_q[0], 32'hA5A5_0F0F);
        loop = 1'b0;
        tick(4);
        pulse_ack();
        chk("lb_ack", 32'(interrupt_eth), 32'd0);
        wait_idle("lb_idle");
        mon_q.delete(); mon_t.delete();

        // five strobes while busy: four queue up, fifth is dropped
        for (int i = 0; i < 6; i++) wv[i] = $urandom;
        snd = 1'b1; interface_data = wv[0]; tick(1); snd = 1'b0;
        tick(3);
        for (int i = 1; i < 6; i++) begin
            snd = 1'b1; interface_data = wv[i]; tick(1);
            if (i == 4) chk("full_after4", 32'(tx_full), 32'd1);
        end
        snd = 1'b0;
        chk("full_after5", 32'(tx_full), 32'd1);
        wait_mon(5, "full_mon_cnt");
        for (int i = 0; i < 5; i++)
            chk("full_word", i < mon_q.size() ? mon_q[i] : 32'hx, wv[i]);
        for (int i = 0; i < 4; i++)
            chk("b2b_gap", i + 1 < mon_t.size() ? 32'(mon_t[i+1] - mon_t[i]) : 32'hx, 32'(34 * CPB + 1));
        wait_idle("full_idle");
        tick(CPB * 40);
        chk("drop_absent", 32'(mon_q.size()), 32'd5);
        mon_q.delete(); mon_t.delete();

        // random bursts from idle: all accepted, full only at five
        for (int r = 0; r < 4; r++) begin
            k = $urandom_range(1, 5);
            exp_q.delete();
            for (int j = 0; j < k; j++) begin
                w = $urandom;
                exp_q.push_back(w);
                snd = 1'b1; interface_data = w; tick(1);
            end
            snd = 1'b0;
            chk("burst_full", 32'(tx_full), 32'(k == 5));
            wait_mon(k, "burst_mon_cnt");
            for (int j = 0; j < k; j++)
                chk("burst_word", j < mon_q.size() ? mon_q[j] : 32'hx, exp_q[j]);
            wait_idle("burst_idle");
            tick(4);
            mon_q.delete(); mon_t.delete();
        end

        // overrun: second word dropped while the first is pending
        send_frame(32'h1, 1'b1);
        send_frame(32'h2, 1'b1);
        chk("ovr_irq", 32'(interrupt_eth), 32'd1);
        chk("ovr_data", interrupt_source_data, 32'h1);
        chk("ovr_flag", 32'(overrun), 32'd1);
        pulse_ack();
        chk("ovr_ack", 32'(interrupt_eth), 32'd0);
        pulse_clr();
        chk("ovr_clr", 32'(overrun), 32'd0);

        // bad stop bit
        send_frame($urandom, 1'b0);
        chk("ferr_flag", 32'(frame_err), 32'd1);
        chk("ferr_irq", 32'(interrupt_eth), 32'd0);
        pulse_clr();
        chk("ferr_clr", 32'(frame_err), 32'd0);

        // one-cycle glitch, then a real frame still decodes
        rx_drv = 1'b0; tick(1); rx_drv = 1'b1; tick(20);
        chk("glitch_irq", 32'(interrupt_eth), 32'd0);
        chk("glitch_ovr", 32'(overrun), 32'd0);
        chk("glitch_ferr", 32'(frame_err), 32'd0);
        send_frame(32'h1234_5678, 1'b1);
        chk("glitch_next", interrupt_source_data, 32'h1234_5678);
        pulse_ack();

        // random RX traffic against the flag model
        m_irq = 1'b0; m_ovr = 1'b0; m_fe = 1'b0; m_data = 32'h1234_5678;
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 2) == 0) begin pulse_ack(); m_irq = 1'b0; end
            if ($urandom_range(0, 4) == 0) begin pulse_clr(); m_ovr = 1'b0; m_fe = 1'b0; end
            w = $urandom;
            good = ($urandom_range(0, 4) != 0);
            send_frame(w, good);
            model_frame(w, good);
            chk("rand_irq", 32'(interrupt_eth), 32'(m_irq));
            chk("rand_data", interrupt_source_data, m_data);
            chk("rand_ovr", 32'(overrun), 32'(m_ovr));
            chk("rand_ferr", 32'(frame_err), 32'(m_fe));
        end

        // reset in the middle of a transmitted frame
        wait_idle("mid_rst_pre");
        snd = 1'b1; interface_data = 32'hCAFE_F00D; tick(1); snd = 1'b0;
        tick(2 + 10 * CPB + 1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_line", 32'(tx_line), 32'd1);
        chk("mid_rst_busy", 32'(tx_busy), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(200);
        mon_q.delete(); mon_t.delete();
        w = $urandom;
        snd = 1'b1; interface_data = w; tick(1); snd = 1'b0;
        wait_mon(1, "post_rst_cnt");
        chk("post_rst_word", mon_q.size() > 0 ? mon_q[0] : 32'hx, w);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
